// File: rtl/uart_word_encoder_if.sv
// Handshake bundle for uart_word_encoder: word-side strobe/busy plus the
// character-side valid/busy toward the byte-wide UART transmitter.
interface uart_word_encoder_if;
   logic        i_stb;
   logic [33:0] i_word;
   logic        o_busy;
   logic        o_stb;
   logic [7:0]  o_data;
   logic        i_busy;

   modport slave (
      input  i_stb,
      input  i_word,
      input  i_busy,
      output o_busy,
      output o_stb,
      output o_data
   );

   modport master (
      output i_stb,
      output i_word,
      output i_busy,
      input  o_busy,
      input  o_stb,
      input  o_data
   );
endinterface

// File: rtl/uart_word_encoder.sv
// Serialises a {cmd[1:0], data[31:0]} word into "<letter><hex digits><TERM_CHAR>".
// Optional macro UART_ENC_ZERO_SUPPRESS_EN skips leading zero nibbles (at least one digit sent).
//
// state | meaning
// IDLE  | waiting for i_stb; o_busy low
// CMD   | presenting the command letter
// HEX   | presenting the top nibble of the shift register as a hex digit
// TERM  | presenting TERM_CHAR
module uart_word_encoder #(
   parameter logic [7:0] TERM_CHAR = 8'h45
) (
   input logic                i_clk,
   input logic                i_rst_n,
   uart_word_encoder_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      HEX  = 2'd2,
      TERM = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] shift_q, shift_d;
   logic [1:0]  cmd_q,   cmd_d;
   logic [3:0]  cnt_q,   cnt_d;

   logic        xfer;
   logic [3:0]  load_cnt;
   logic [31:0] load_shift;
   logic [7:0]  data_c;

   function automatic logic [7:0] hex_char(input logic [3:0] nib);
      return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
   endfunction

   function automatic logic [7:0] cmd_char(input logic [1:0] cmd);
      logic [7:0] c;
      case (cmd)
         2'b00:   c = 8'h52;
         2'b01:   c = 8'h57;
         2'b10:   c = 8'h41;
         default: c = 8'h53;
      endcase
      return c;
   endfunction

`ifdef UART_ENC_ZERO_SUPPRESS_EN
   // Digit count is the position of the highest non-zero nibble; data 0 still sends one digit.
   always_comb begin
      load_cnt = 4'd1;
      for (int i = 1; i < 8; i++) begin
         if (bus.i_word[4*i +: 4] != 4'h0) load_cnt = 4'(i + 1);
      end
      load_shift = bus.i_word[31:0] << {4'd8 - load_cnt, 2'b00};
   end
`else
   assign load_cnt   = 4'd8;
   assign load_shift = bus.i_word[31:0];
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         shift_q <= '0;
         cmd_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cmd_q   <= cmd_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cmd_d   = cmd_q;
      cnt_d   = cnt_q;
      xfer    = (state_q != IDLE) && !bus.i_busy;

      case (state_q)
         IDLE: begin
            if (bus.i_stb) begin
               shift_d = load_shift;
               cmd_d   = bus.i_word[33:32];
               cnt_d   = load_cnt;
               state_d = CMD;
            end
         end
         CMD: begin
            if (xfer) state_d = HEX;
         end
         HEX: begin
            if (xfer) begin
               shift_d = {shift_q[27:0], 4'h0};
               cnt_d   = cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_d = TERM;
            end
         end
         TERM: begin
            if (xfer) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode registered state only, so i_stb/i_busy never reach them combinationally.
   always_comb begin
      data_c = 8'h00;
      case (state_q)
         CMD:     data_c = cmd_char(cmd_q);
         HEX:     data_c = hex_char(shift_q[31:28]);
         TERM:    data_c = TERM_CHAR;
         default: data_c = 8'h00;
      endcase
   end

   assign bus.o_data = data_c;
   assign bus.o_stb  = (state_q != IDLE);
   assign bus.o_busy = (state_q != IDLE);

endmodule

// File: doc/uart_word_encoder.md
# uart_word_encoder

Transmit-side companion to the UART command decoder. Takes a 34-bit word (2-bit command code plus 32-bit data) and serialises it into the ASCII character stream the decoder parses: a command letter, lowercase hex digits MSB-first, then a terminator. Sits between the Wishbone-side response logic and the byte-wide UART transmitter. It hands one character at a time to the transmitter under a valid/busy handshake.

## Interface
- `TERM_CHAR`, default 8'h45 ('E'): terminator character emitted after the last hex digit.
- `i_clk`  in  1  system clock, all logic on rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_stb`  in  1  word valid; accepted when `i_stb && !o_busy`.
- `i_word`  in  34  [33:32] command code, [31:0] data; sampled on acceptance.
- `o_busy`  out  1  high while a word is being serialised.
- `o_stb`  out  1  character valid toward the UART transmitter.
- `o_data`  out  8  ASCII character; bit 7 always 0.
- `i_busy`  in  1  transmitter busy; character transferred on a cycle with `o_stb && !i_busy`.

## Operation
- Command letter from [33:32]: 00 → 'R' (8'h52), 01 → 'W' (8'h57), 10 → 'A' (8'h41), 11 → 'S' (8'h53).
- Hex digit mapping: nibble 0–9 → 8'h30–8'h39; a–f → 8'h61–8'h66, lowercase only.
- FSM states:
  - IDLE: on acceptance, latch `i_word` into a 32-bit shift register and a 2-bit command register. Load digit count 8, or the suppressed count (see Configuration). Go to CMD.
  - CMD: present the command letter. On transfer go to HEX.
  - HEX: present the top nibble of the shift register. On transfer, shift left 4 and decrement the count. After the last digit transfers, go to TERM.
  - TERM: present `TERM_CHAR`. On transfer go to IDLE.
- `o_busy` = (state != IDLE), driven from registered state.
- `o_stb` is high in CMD, HEX and TERM.
- `o_stb` and `o_data` hold stable until the character transfers. No character is dropped or repeated.
- `i_stb` while `o_busy` is high is ignored. Nothing is queued, and the latched word is not disturbed.
- The digit counter is 4 bits, range 1–8. It never wraps: the HEX→TERM exit fires at count 1.

## Timing
- Reset values: state IDLE, `o_stb` 0, `o_data` 8'h00, `o_busy` 0, shift register 0, counter 0.
- Reset asserted mid-word aborts immediately. No terminator is sent, and the next word starts fresh.
- Acceptance edge N → `o_stb` high with the command letter from cycle N+1.
- A transfer at edge M → the next character appears on `o_data` in cycle M+1. With `i_busy` held low, this gives one character per clock.
- Full 8-digit word with no backpressure: `o_stb` high for cycles N+1..N+10. `o_busy` drops at N+11, where a new word may be accepted. Minimum word period is 11 cycles.
- Backpressure: each cycle with `i_busy` high while `o_stb` is high adds one cycle. Outputs stay frozen during it.
- `i_stb` and `i_busy` are never combinationally routed to any output.

## Configuration
- `UART_ENC_ZERO_SUPPRESS_EN`:
  - Defined: leading zero nibbles of [31:0] are skipped. The word is pre-shifted on acceptance and the digit count is reduced to match. At least one digit is always sent, so data 0 → single '0'. Word period shrinks accordingly; minimum is 4 cycles.
  - Undefined: always exactly 8 digits, and the pre-shift logic is absent.

## Test plan
- i_word = {2'b01, 32'h0000_00a5}, `i_busy` 0:
  - Without the macro → "W000000a5E" on 10 consecutive cycles.
  - With the macro → "Wa5E" on 4 consecutive cycles.
- i_word = {2'b10, 32'hdead_beef}, `i_busy` toggled high every other cycle → "AdeadbeefE". Each character is held stable while `i_busy` is high and transferred exactly once.
- i_word = {2'b00, 32'h0}:
  - Without the macro → "R00000000E".
  - With the macro → "R0E".
- Second `i_stb` with {2'b11, 32'h1} pulsed during the first word's HEX state → ignored. Only the first word is emitted, and `o_busy` stays high until TERM transfers.
- Back-to-back words with `i_stb` held high → second word accepted on the first cycle `o_busy` is low (cycle N+11 without the macro). Its command letter appears at N+12.
- `i_rst_n` pulsed low during HEX digit 3 → `o_stb`, `o_busy` and `o_data` are 0 asynchronously. After release, a new word {2'b01, 32'h1234_5678} → "W12345678E".
